// File: rtl/premuat_pkg.sv
// Shared definitions for the premuat lane-reorder pipe: size codes, point
// count decode and packed-bus lane offset helper.
package premuat_pkg;

  localparam logic [1:0] SZ4  = 2'd0;
  localparam logic [1:0] SZ8  = 2'd1;
  localparam logic [1:0] SZ16 = 2'd2;
  localparam logic [1:0] SZ32 = 2'd3;

  function automatic int unsigned size_n(input logic [1:0] sz);
    return 32'd4 << sz;
  endfunction

  // Bit offset of lane k on a bus of w-bit lanes
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/premuat_perm.sv
// Combinational butterfly interleave / de-interleave of the first n lanes;
// lanes at or above n, and every lane when disabled, pass straight through.
module premuat_perm
  import premuat_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 32
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic [1:0]             i_size,
  input  logic                   i_inverse,
  input  logic                   i_enable,
  output logic [LANES*WIDTH-1:0] o_data
);

  localparam int IW = $clog2(LANES);

  logic [WIDTH-1:0] w_in [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned K = k;
    logic [IW-1:0] w_src;

    assign w_in[k] = i_data[lane_lo(K, WIDTH) +: WIDTH];

    always_comb begin
      int unsigned n, h, s;
      n = size_n(i_size);
      h = n / 2;
      s = K;
      if (i_enable && K < n) begin
        if (!i_inverse) s = (K % 2 == 0) ? K / 2 : K / 2 + h;
        else            s = (K < h) ? 2 * K : 2 * (K - h) + 1;
      end
      w_src = IW'(s);
    end

    assign o_data[lane_lo(K, WIDTH) +: WIDTH] = w_in[w_src];
  end

endmodule

// File: rtl/premuat_pipe.sv
// Registered valid/ready lane-reorder stage, 1-cycle latency. Define
// PREMUAT_SKID_EN for a 2-entry skid output with a flopped i_ready.
module premuat_pipe
  import premuat_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [1:0]             i_size,
  input  logic                   i_inverse,
  input  logic                   i_enable,
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [LANES*WIDTH-1:0] o_data
);

  logic [LANES*WIDTH-1:0] w_perm;
  logic                   r_valid;
  logic [LANES*WIDTH-1:0] r_data;
  logic                   w_acc;

  premuat_perm #(.WIDTH(WIDTH), .LANES(LANES)) u_perm (
    .i_data    (i_data),
    .i_size    (i_size),
    .i_inverse (i_inverse),
    .i_enable  (i_enable),
    .o_data    (w_perm)
  );

  assign w_acc   = i_valid & i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

`ifdef PREMUAT_SKID_EN
  logic                   r_skid_empty;
  logic [LANES*WIDTH-1:0] r_skid_data;
  logic                   w_out_free;

  assign i_ready    = r_skid_empty;
  assign w_out_free = o_ready | ~r_valid;

  // A held skid beat always goes out before anything new is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_skid_empty <= 1'b1;
      r_skid_data  <= '0;
    end else if (!r_skid_empty) begin
      if (w_out_free) begin
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_skid_empty <= 1'b1;
      end
    end else if (w_acc) begin
      if (w_out_free) begin
        r_valid <= 1'b1;
        r_data  <= w_perm;
      end else begin
        r_skid_empty <= 1'b0;
        r_skid_data  <= w_perm;
      end
    end else if (o_ready) begin
      r_valid <= 1'b0;
    end
  end
`else
  assign i_ready = o_ready | ~r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_perm;
    end else if (o_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_premuat_pipe.sv
// Scoreboard bench for premuat_pipe: directed rows in, expected rows queued,
// monitor pops and compares every output handshake.
module tb_premuat_pipe;
  import premuat_pkg::*;

  localparam int WIDTH = 16;
  localparam int LANES = 32;
  typedef logic [LANES*WIDTH-1:0] row_t;

  logic clk = 1'b0;
  logic rst, i_valid, i_ready, i_inverse, i_enable, o_valid, o_ready;
  logic [1:0] i_size;
  row_t i_data, o_data;

  int checks = 0;
  int errors = 0;
  row_t sb[$];

  int F16[16] = '{0,8,1,9,2,10,3,11,4,12,5,13,6,14,7,15};
  int I8[8]   = '{0,2,4,6,1,3,5,7};
  int F32[32] = '{0,16,1,17,2,18,3,19,4,20,5,21,6,22,7,23,
                  8,24,9,25,10,26,11,27,12,28,13,29,14,30,15,31};

  premuat_pipe #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_size(i_size), .i_inverse(i_inverse), .i_enable(i_enable),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  always #5 clk = ~clk;

  function automatic row_t ident();
    row_t r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = 16'(k);
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input row_t act, input row_t exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input row_t d, input logic [1:0] sz, input logic inv,
                      input logic en, input row_t exp);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    i_valid = 1'b1; i_data = d; i_size = sz; i_inverse = inv; i_enable = en;
    sb.push_back(exp);
    while (!acc) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        chk(1'b0, "accept_timeout", row_t'(n), '0);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(sb.size() == 0, nm, row_t'(sb.size()), '0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on each output handshake and check stall stability
  initial begin
    bit   stall;
    row_t stall_data, exp;
    stall = 0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
      end else begin
        if (stall) chk(o_valid && o_data == stall_data, "stall_stable", o_data, stall_data);
        stall = o_valid && !o_ready;
        stall_data = o_data;
        if (o_valid && o_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_beat", o_data, '0);
          end else begin
            exp = sb.pop_front();
            chk(o_data === exp, "beat_data", o_data, exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got %0d want 0", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    row_t d, e, e1;
    bit r;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_size = SZ4;
    i_inverse = 1'b0; i_enable = 1'b0; o_ready = 1'b1;

    #12;
    chk(o_valid == 1'b0, "reset_o_valid", row_t'(o_valid), '0);
    chk(o_data == '0,    "reset_o_data", o_data, '0);
    chk(i_ready == 1'b1, "reset_i_ready", row_t'(i_ready), row_t'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // forward 16
    e = ident();
    for (int k = 0; k < 16; k++) e[k*WIDTH +: WIDTH] = 16'(F16[k]);
    send(ident(), SZ16, 1'b0, 1'b1, e);
    chk(o_valid == 1'b1, "latency_1", row_t'(o_valid), row_t'(1));

    // inverse 8
    e = ident();
    for (int k = 0; k < 8; k++) e[k*WIDTH +: WIDTH] = 16'(I8[k]);
    send(ident(), SZ8, 1'b1, 1'b1, e);

    // size 32 forward then inverse of that result
    e1 = ident();
    for (int k = 0; k < 32; k++) e1[k*WIDTH +: WIDTH] = 16'(F32[k]);
    send(ident(), SZ32, 1'b0, 1'b1, e1);
    send(e1, SZ32, 1'b1, 1'b1, ident());

    // disabled then enabled size 4 inverse, back to back
    send(ident(), SZ4, 1'b1, 1'b0, ident());
    e = ident();
    e[1*WIDTH +: WIDTH] = 16'd2;
    e[2*WIDTH +: WIDTH] = 16'd1;
    send(ident(), SZ4, 1'b1, 1'b1, e);
    wait_drain("drain_basic");

    // backpressure: 4 beats, o_ready low for 3 edges mid-stream
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          d = ident();
          d[WIDTH-1:0] = 16'(100 + b);
          e = d;
          e[1*WIDTH +: WIDTH] = 16'd2;
          e[2*WIDTH +: WIDTH] = 16'd1;
          send(d, SZ4, 1'b0, 1'b1, e);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        r = i_ready;
        o_ready = 1'b0;
        #1;
`ifdef PREMUAT_SKID_EN
        chk(i_ready == r, "iready_comb_drop", row_t'(i_ready), row_t'(r));
`endif
        repeat (3) @(posedge clk);
        #1;
        r = i_ready;
        o_ready = 1'b1;
        #1;
`ifdef PREMUAT_SKID_EN
        chk(i_ready == r, "iready_comb_rise", row_t'(i_ready), row_t'(r));
`endif
      end
    join
    wait_drain("drain_bp");

    // async reset while a beat is stalled
    o_ready = 1'b0;
    d = ident();
    d[WIDTH-1:0] = 16'd77;
    send(d, SZ4, 1'b0, 1'b0, d);
    @(posedge clk);
    #1;
    chk(o_valid == 1'b1, "stall_before_rst", row_t'(o_valid), row_t'(1));
    #2;
    rst = 1'b1;
    #1;
    chk(o_valid == 1'b0, "rst_async_o_valid", row_t'(o_valid), '0);
    chk(o_data == '0,    "rst_async_o_data", o_data, '0);
    chk(i_ready == 1'b1, "rst_async_i_ready", row_t'(i_ready), row_t'(1));
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    d = ident();
    d[WIDTH-1:0] = 16'd55;
    send(d, SZ16, 1'b0, 1'b0, d);
    wait_drain("drain_after_rst");
    repeat (5) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/premuat_pipe.md
# premuat_pipe

Registered, parametrised successor of the fixed 16-point butterfly premutation used between transform stages in the tq path. It reorders the active lanes of one coefficient row per beat, for 4/8/16/32-point transforms, in forward (interleave) or inverse (de-interleave) mode. It uses a valid/ready handshake so it can sit between stalling pipeline stages of the DCT/IDCT datapath.

## Interface
- WIDTH, 16, bits per coefficient lane (signed)
- LANES, 32, lane count of the data bus; must be 32 (supports size code 3)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_valid  input  1  input beat present
- i_ready  output  1  block can accept a beat this cycle
- i_size  input  2  transform size of this beat: 0=4, 1=8, 2=16, 3=32 points (n)
- i_inverse  input  1  1 = de-interleave (inverse), 0 = interleave (forward)
- i_enable  input  1  0 = pass all lanes through unchanged
- i_data  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- o_valid  output  1  output beat present
- o_ready  input  1  downstream accepts this cycle
- o_data  output  LANES*WIDTH  permuted row, same packing

## Operation
- Transfer occurs on a side when valid & ready are both high at a rising edge. i_size, i_inverse and i_enable are sampled with the same beat as i_data. They have no effect on other beats.
- Let n = 4 << i_size and h = n/2. For lanes k < n:
  - Forward: out[2j] = in[j], out[2j+1] = in[j+h], for j in 0..h-1.
  - Inverse: out[j] = in[2j], out[j+h] = in[2j+1], for j in 0..h-1.
  - Lane 0 and lane n-1 are therefore always unchanged.
- Lanes k >= n: out[k] = in[k].
- i_enable = 0: out = in for all lanes.
- Data is moved only, never modified. No arithmetic and no sign handling.
- Beats are never dropped, duplicated or reordered.

## Timing
- Latency is 1 cycle. A beat accepted at edge t is presented on o_data/o_valid after edge t.
- Throughput is 1 beat/cycle while o_ready is held high.
- o_data and o_valid hold stable while o_valid=1 and o_ready=0.
- On a simultaneous output drain and input accept, the new beat replaces the old beat in the same edge. There is no bubble.
- Reset (asynchronous, at any time including mid-stall):
  - o_valid=0, o_data=0, all internal valid bits cleared.
  - Any in-flight beats are discarded.
  - i_ready goes to 1 without waiting for a clock edge; the first accept can occur on the first edge after rst deasserts.
- Changing i_size, i_inverse or i_enable while i_valid=0 has no effect.

## Configuration
- PREMUAT_SKID_EN defined:
  - A 2-entry skid buffer (output register plus skid register) is placed at the output.
  - i_ready is driven directly from a flop, with no combinational path from o_ready. i_ready = skid register empty.
  - When o_ready drops with a beat in flight, the beat is held in the skid register. i_ready deasserts the cycle after the skid register fills.
  - The skid register drains to the output first on the next o_ready.
- PREMUAT_SKID_EN undefined:
  - There is a single output register.
  - i_ready = o_ready | ~o_valid (combinational).
- Latency, data mapping and reset values are identical in both builds.

## Structure
- Shared package premuat_pkg holds:
  - the size code constants SZ4/SZ8/SZ16/SZ32;
  - a function returning n from the size code;
  - the lane-extraction helper for the packed bus.
- Sub-module premuat_perm is the purely combinational mapping: in, size, inverse, enable -> out, for all LANES.
- premuat_pipe instantiates premuat_perm ahead of the register stage and implements the handshake and the optional skid buffer.

## Test plan
- In all scenarios, lane k of i_data carries value k unless stated otherwise.
- Forward, size 16, enable=1: o_data lanes 0..15 = 0,8,1,9,2,10,...,7,15; lanes 16..31 = 16..31; o_valid one cycle after accept.
- Inverse, size 8, enable=1: lanes 0..7 = 0,2,4,6,1,3,5,7; lanes 8..31 unchanged.
- Size 32, forward then inverse (two beats, second beat fed the first beat's output): after the forward beat lane 1 = 16 and lane 30 = 15; after the inverse beat the row is restored to 0..31.
- enable=0 with size 4 and inverse=1: output equals input exactly. Then a back-to-back beat with enable=1, size 4, inverse=1: lanes 0..3 = 0,2,1,3.
- Backpressure: stream 4 beats with lane 0 = 100..103 while o_ready is low for 3 cycles mid-stream:
  - all 4 beats emerge in order, 100..103;
  - o_data is stable while stalled;
  - with PREMUAT_SKID_EN, i_ready never depends combinationally on o_ready.
- Reset asserted asynchronously while a beat is stalled: o_valid=0 and o_data=0 immediately; after release, a beat with lane 0 = 55 emerges alone and the stalled beat never appears.
